// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - RV32I format tags, opcodes and field positions shared with instruction_decode
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    // True when v[31:lsb] are all copies of one bit, i.e. v sign-extends from bit lsb.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational format mux and immediate range checks for one field bundle
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err
);

    logic w_is_shift;

    assign w_is_shift = (i_opcode == OP_IMM) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

    always_comb begin
        o_word = NOP_INSTR;
        o_err  = 1'b0;
        case (fmt_e'(i_fmt))
            FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                if (w_is_shift) begin
                    o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                    o_err  = |i_imm[31:5];
                end else begin
                    o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                    o_err  = !upper_uniform(i_imm, 11);
                end
            end
            FMT_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = !upper_uniform(i_imm, 11);
            end
            FMT_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_err  = !upper_uniform(i_imm, 12) || i_imm[0];
            end
            FMT_U: begin
                o_word = {i_imm[31:12], i_rd, i_opcode};
                o_err  = |i_imm[11:0];
            end
            FMT_J: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = !upper_uniform(i_imm, 20) || i_imm[0];
            end
            // Illegal tags still produce a harmless word so the memory image stays executable.
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I encoder with registered output, word address counter and full stop
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    logic [31:0]     w_word;
    logic            w_err;
    logic            w_handshake;
    logic            w_accept;
    logic            w_full_pending;
    logic [ADDR_W:0] w_issued;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic              r_sticky;
    logic [ADDR_W:0]   r_count;

    instr_pack u_pack (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_rd     (rd),
        .i_funct3 (funct3),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_funct7 (funct7),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_err    (w_err)
    );

    // Words handed off plus the one sitting in the register: also the next free address.
    assign w_issued       = r_count + {{ADDR_W{1'b0}}, r_valid};
    assign w_full_pending = w_issued >= (ADDR_W+1)'(DEPTH);
    assign w_handshake    = r_valid && out_ready;
    assign in_ready       = !clear && !w_full_pending && (!r_valid || out_ready);
    assign w_accept       = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_addr   <= '0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (clear) begin
            r_valid  <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_handshake) begin
                r_count <= r_count + 1'b1;
            end
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_instr  <= w_word;
                r_addr   <= w_issued[ADDR_W-1:0];
                r_err    <= w_err;
                r_sticky <= r_sticky | w_err;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_instr  = r_instr;
    assign out_addr   = r_addr;
    assign out_err    = r_err;
    assign err_sticky = r_sticky;
    assign count      = r_count;
    assign full       = r_count == (ADDR_W+1)'(DEPTH);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed bench with a behavioural model checking a 256-deep and a 4-deep encoder
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        in_ready0, out_valid0, out_err0, err_sticky0, full0;
    logic [31:0] out_instr0;
    logic [7:0]  out_addr0;
    logic [8:0]  count0;
    logic        in_ready1, out_valid1, out_err1, err_sticky1, full1;
    logic [31:0] out_instr1;
    logic [1:0]  out_addr1;
    logic [2:0]  count1;

    instr_encoder #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_addr(out_addr0), .out_err(out_err0),
        .err_sticky(err_sticky0), .count(count0), .full(full0)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .out_valid(out_valid1), .out_ready(out_ready),
        .out_instr(out_instr1), .out_addr(out_addr1), .out_err(out_err1),
        .err_sticky(err_sticky1), .count(count1), .full(full1)
    );

    logic        a_ready[2], a_valid[2], a_err[2], a_sticky[2], a_full[2];
    logic [31:0] a_instr[2], a_addr[2], a_count[2];

    assign a_ready[0] = in_ready0;   assign a_ready[1] = in_ready1;
    assign a_valid[0] = out_valid0;  assign a_valid[1] = out_valid1;
    assign a_err[0]   = out_err0;    assign a_err[1]   = out_err1;
    assign a_sticky[0] = err_sticky0; assign a_sticky[1] = err_sticky1;
    assign a_full[0]  = full0;       assign a_full[1]  = full1;
    assign a_instr[0] = out_instr0;  assign a_instr[1] = out_instr1;
    assign a_addr[0]  = {24'd0, out_addr0};  assign a_addr[1]  = {30'd0, out_addr1};
    assign a_count[0] = {23'd0, count0};     assign a_count[1] = {29'd0, count1};

    localparam int MD[2] = '{256, 4};

    int n_checks = 0;
    int n_fail   = 0;
    int hs1      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoding from the ISA field rules and numeric immediate ranges.
    function automatic logic [32:0] enc(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                        input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w, u, base;
        int          s;
        logic        e;
        u = im;
        s = int'($signed(im));
        base = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15);
        e = 1'b0;
        case (f)
            3'd0: w = base | (32'(s2) << 20) | (32'(f7) << 25);
            3'd1: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = base | ((u & 32'h1F) << 20) | (32'(f7) << 25);
                    e = u > 32'd31;
                end else begin
                    w = base | ((u & 32'hFFF) << 20);
                    e = (s < -2048) || (s > 2047);
                end
            end
            3'd2: begin
                w = 32'(op) | ((u & 32'h1F) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                    | (32'(s2) << 20) | (((u >> 5) & 32'h7F) << 25);
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = 32'(op) | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8)
                    | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                    | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
                e = (s < -4096) || (s > 4095) || u[0];
            end
            3'd4: begin
                w = 32'(op) | (32'(d) << 7) | (u & 32'hFFFF_F000);
                e = (u & 32'hFFF) != 32'd0;
            end
            3'd5: begin
                w = 32'(op) | (32'(d) << 7) | (((u >> 12) & 32'hFF) << 12)
                    | (((u >> 11) & 32'h1) << 20) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 20) & 32'h1) << 31);
                e = (s < -1048576) || (s > 1048575) || u[0];
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    // Model: one output slot per instance; addresses number accepted bundles since reset/clear.
    bit          mv[2]   = '{0, 0};
    logic [31:0] mw[2]   = '{0, 0};
    int          ma[2]   = '{0, 0};
    bit          me[2]   = '{0, 0};
    int          mc[2]   = '{0, 0};
    bit          ms[2]   = '{0, 0};
    int          macc[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clear) begin
                mv[k]   <= 1'b0;
                mc[k]   <= 0;
                ms[k]   <= 1'b0;
                macc[k] <= 0;
            end else begin
                logic [32:0] r;
                bit          take;
                bit          hs;
                hs   = mv[k] && out_ready;
                take = in_valid && (macc[k] < MD[k]) && (!mv[k] || out_ready);
                r    = enc(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
                if (hs) mc[k] <= mc[k] + 1;
                if (take) begin
                    mv[k]   <= 1'b1;
                    mw[k]   <= r[31:0];
                    me[k]   <= r[32];
                    ma[k]   <= macc[k];
                    macc[k] <= macc[k] + 1;
                    ms[k]   <= ms[k] | r[32];
                end else if (hs) begin
                    mv[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_out_valid", k), 32'(a_valid[k]), 32'(mv[k]));
            if (mv[k]) begin
                chk($sformatf("d%0d_out_instr", k), a_instr[k], mw[k]);
                chk($sformatf("d%0d_out_addr", k), a_addr[k], 32'(ma[k]));
                chk($sformatf("d%0d_out_err", k), 32'(a_err[k]), 32'(me[k]));
            end
            chk($sformatf("d%0d_in_ready", k), 32'(a_ready[k]),
                32'(!clear && (macc[k] < MD[k]) && (!mv[k] || out_ready)));
            chk($sformatf("d%0d_err_sticky", k), 32'(a_sticky[k]), 32'(ms[k]));
            chk($sformatf("d%0d_count", k), a_count[k], 32'(mc[k]));
            chk($sformatf("d%0d_full", k), 32'(a_full[k]), 32'(mc[k] == MD[k]));
        end
        if (rst_n && !clear && out_valid1 && out_ready) hs1++;
    end

    task automatic offer(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic wait_acc(input int sel);
        bit rdy;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            rdy = (sel == 1) ? in_ready1 : in_ready0;
            @(posedge clk);
            #2;
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_out(input string nm, input logic [31:0] ins, input logic [31:0] adr,
                             input logic e);
        chk({nm, "_valid"}, 32'(out_valid0), 32'd1);
        chk({nm, "_instr"}, out_instr0, ins);
        chk({nm, "_addr"}, {24'd0, out_addr0}, adr);
        chk({nm, "_err"}, 32'(out_err0), 32'(e));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0; imm = '0;
        @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_instr", out_instr0, 32'd0);
        chk("rst_count", {23'd0, count0}, 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);

        // Field encoding, back to back
        offer(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);       wait_acc(0);
        check_out("add", 32'h002081B3, 32'd0, 1'b0);
        offer(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);       wait_acc(0);
        check_out("addi", 32'h00500093, 32'd1, 1'b0);
        offer(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8);       wait_acc(0);
        check_out("sw", 32'h0020A423, 32'd2, 1'b0);
        offer(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, -32'sd4);     wait_acc(0);
        check_out("beq", 32'hFE208EE3, 32'd3, 1'b0);
        offer(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000); wait_acc(0);
        check_out("lui", 32'h123452B7, 32'd4, 1'b0);
        offer(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048);    wait_acc(0);
        check_out("jal", 32'h001000EF, 32'd5, 1'b0);
        offer(3'd1, 7'h13, 5'd1, 3'd5, 5'd1, 5'd0, 7'h20, 32'd3);       wait_acc(0);
        check_out("srai", 32'h4030D093, 32'd6, 1'b0);
        idle(2);

        // Backpressure: held word stays put, next one follows at addr+1
        out_ready = 1'b0;
        offer(3'd0, 7'h33, 5'd4, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);       wait_acc(0);
        offer(3'd0, 7'h33, 5'd5, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready0), 32'd0);
            chk("stall_instr", out_instr0, 32'h00208233);
            chk("stall_addr", {24'd0, out_addr0}, 32'd7);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        wait_acc(0);
        check_out("after_stall", 32'h002082B3, 32'd8, 1'b0);
        idle(2);

        // Encodability errors
        offer(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048);    wait_acc(0);
        check_out("addi_2048", 32'h80000093, 32'd9, 1'b1);
        chk("sticky_set", 32'(err_sticky0), 32'd1);
        offer(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'd3);       wait_acc(0);
        check_out("beq_odd", 32'h00208163, 32'd10, 1'b1);
        offer(3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);       wait_acc(0);
        check_out("fmt7", 32'h00000013, 32'd11, 1'b1);
        idle(3);
        chk("sticky_held", 32'(err_sticky0), 32'd1);

        // Clear while a word is stalled
        out_ready = 1'b0;
        offer(3'd0, 7'h33, 5'd6, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);       wait_acc(0);
        offer(3'd0, 7'h33, 5'd7, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
        clear = 1'b1;
        #1;
        chk("clear_in_ready", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #2;
        clear = 1'b0;
        chk("clear_valid", 32'(out_valid0), 32'd0);
        chk("clear_count", {23'd0, count0}, 32'd0);
        chk("clear_full", 32'(full0), 32'd0);
        chk("clear_sticky", 32'(err_sticky0), 32'd0);
        chk("clear_small_full", 32'(full1), 32'd0);
        out_ready = 1'b1;
        wait_acc(0);
        check_out("post_clear", 32'h002083B3, 32'd0, 1'b0);
        idle(2);

        // Full on the 4-deep instance: six offers, four handshakes
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        base = hs1;
        for (int i = 0; i < 6; i++) begin
            offer(3'd1, 7'h13, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'h00, 32'(i));
            idle(1);
        end
        #1;
        chk("full_in_ready", 32'(in_ready1), 32'd0);
        in_valid = 1'b0;
        idle(2);
        chk("full_count", {29'd0, count1}, 32'd4);
        chk("full_flag", 32'(full1), 32'd1);
        chk("full_handshakes", 32'(hs1 - base), 32'd4);

        // Asynchronous reset between edges
        offer(3'd0, 7'h33, 5'd9, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
        idle(1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid0), 32'd0);
        chk("arst_instr", out_instr0, 32'd0);
        chk("arst_addr", {24'd0, out_addr0}, 32'd0);
        chk("arst_err", 32'(out_err0), 32'd0);
        chk("arst_count", {23'd0, count0}, 32'd0);
        chk("arst_small_full", 32'(full1), 32'd0);
        chk("arst_small_count", {29'd0, count1}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
